// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty clock divider with edge strobes, busy-handshake divisor reload and drain-on-disable.
// Define CLK_DIV_QUAD_EN to add the 90-degree lagging clk_q output; otherwise clk_q is tied low.
module clk_div_prog #(
  parameter int          CNT_W   = 16,
  parameter int unsigned DIV_RST = 14706
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             clk_q,
  output logic             running
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] div_cur, div_pend;
  logic             clk_out_nxt, clk_q_nxt, rise_nxt, fall_nxt;
  logic             counting, draining, terminal, tgl, apply;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: leave DRAIN only once every output clock has settled low
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = (clk_out_nxt || clk_q_nxt) ? DRAIN : IDLE;
      DRAIN:   if (!clk_out_nxt && !clk_q_nxt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: counter advance and toggle decisions for the coming edge
  always_comb begin
    counting    = (state == DRAIN) || ((state == RUN) && (en || clk_out || clk_q));
    draining    = (state == DRAIN) || ((state == RUN) && !en);
    terminal    = (cnt == div_cur);
    tgl         = 1'b0;
    cnt_nxt     = '0;
    clk_out_nxt = 1'b0;
    clk_q_nxt   = 1'b0;
    rise_nxt    = 1'b0;
    fall_nxt    = 1'b0;
    if (counting) begin
      // While draining, a low clk_out must not be allowed to rise again
      tgl         = terminal && (!draining || clk_out);
      cnt_nxt     = terminal ? '0 : cnt + 1'b1;
      clk_out_nxt = clk_out ^ tgl;
      rise_nxt    = tgl & ~clk_out;
      fall_nxt    = tgl & clk_out;
`ifdef CLK_DIV_QUAD_EN
      clk_q_nxt   = clk_q ^ ((cnt == (div_cur >> 1)) && (clk_q != clk_out));
`endif
    end
  end

  // New divisor takes effect only on a full-period boundary, or right away when stopped
  assign apply = div_busy && (fall_nxt || (state == IDLE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      div_cur   <= CNT_W'(DIV_RST);
      div_pend  <= '0;
      div_busy  <= 1'b0;
      clk_out   <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      running   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      clk_out   <= clk_out_nxt;
      rise_tick <= rise_nxt;
      fall_tick <= fall_nxt;
      running   <= (state_nxt != IDLE);
      if (apply) div_cur <= div_pend;
      if (div_load) begin
        div_pend <= div_in;
        div_busy <= 1'b1;
      end else if (apply) begin
        div_busy <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_QUAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_q <= 1'b0;
    else     clk_q <= clk_q_nxt;
  end
`else
  assign clk_q = 1'b0;
`endif

endmodule
